// File: rtl/exm_pkg.sv
// Shared types and widths for the execute-to-memory skid register.
package exm_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned ELEM_W = 16;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned DATA_W = LANES * ELEM_W;
    localparam int unsigned CNT_W  = 2;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              pc_src;
        logic              mem_to_reg;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] write_data;
        logic [REG_AW-1:0] wa;
    } exm_bundle_t;

    typedef enum logic [CNT_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } exm_count_e;

    // A condition-failed instruction carries no architectural side effect.
    function automatic logic is_nop(input exm_bundle_t b);
        return ~(b.reg_write | b.mem_write | b.pc_src);
    endfunction

endpackage

// File: rtl/exm_slot.sv
// One bundle register: async active-low reset, synchronous clear (priority) and load enable.
module exm_slot
    import exm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  exm_bundle_t d,
    output exm_bundle_t q
);

    exm_bundle_t data_d;
    exm_bundle_t data_q;

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM 2-entry skid buffer; in_ready depends only on state, never on out_ready.
// Optional macro EXM_DROP_NOP_EN: accept but discard bundles with all write enables clear.
module ex_mem_skid_reg
    import exm_pkg::*;
#(
    parameter int unsigned LANES  = exm_pkg::LANES,
    parameter int unsigned ELEM_W = exm_pkg::ELEM_W,
    parameter int unsigned REG_AW = exm_pkg::REG_AW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_reg_write,
    input  logic                      in_mem_write,
    input  logic                      in_pc_src,
    input  logic                      in_mem_to_reg,
    input  logic [LANES*ELEM_W-1:0]   in_alu_result,
    input  logic [LANES*ELEM_W-1:0]   in_write_data,
    input  logic [REG_AW-1:0]         in_wa,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_reg_write,
    output logic                      out_mem_write,
    output logic                      out_pc_src,
    output logic                      out_mem_to_reg,
    output logic [LANES*ELEM_W-1:0]   out_alu_result,
    output logic [LANES*ELEM_W-1:0]   out_write_data,
    output logic [REG_AW-1:0]         out_wa,
    output logic [1:0]                occupancy
);

    exm_count_e  count_q;
    exm_count_e  count_d;
    exm_bundle_t in_bundle;
    exm_bundle_t head_q;
    exm_bundle_t skid_q;
    exm_bundle_t head_in;
    exm_bundle_t out_bundle;
    logic        push;
    logic        pop;
    logic        store;
    logic        head_load;
    logic        skid_load;
    logic        head_sel_skid;

    assign in_bundle.reg_write  = in_reg_write;
    assign in_bundle.mem_write  = in_mem_write;
    assign in_bundle.pc_src     = in_pc_src;
    assign in_bundle.mem_to_reg = in_mem_to_reg;
    assign in_bundle.alu_result = in_alu_result;
    assign in_bundle.write_data = in_write_data;
    assign in_bundle.wa         = in_wa;

    assign in_ready  = reset & (count_q != TWO);
    assign out_valid = (count_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef EXM_DROP_NOP_EN
    assign store = push & ~is_nop(in_bundle);
`else
    assign store = push;
`endif

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= EMPTY;
        end else begin
            count_q <= count_d;
        end
    end

    // Next occupancy and slot load controls; flush overrides everything.
    always_comb begin
        count_d       = count_q;
        head_load     = 1'b0;
        skid_load     = 1'b0;
        head_sel_skid = 1'b0;
        if (flush) begin
            count_d = EMPTY;
        end else begin
            case (count_q)
                EMPTY: begin
                    if (store) begin
                        head_load = 1'b1;
                        count_d   = ONE;
                    end
                end
                ONE: begin
                    if (store && pop) begin
                        head_load = 1'b1;
                    end else if (store) begin
                        skid_load = 1'b1;
                        count_d   = TWO;
                    end else if (pop) begin
                        count_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_load     = 1'b1;
                        head_sel_skid = 1'b1;
                        count_d       = ONE;
                    end
                end
                default: begin
                    count_d = EMPTY;
                end
            endcase
        end
    end

    assign head_in = head_sel_skid ? skid_q : in_bundle;

    exm_slot u_head (
        .clk   (clk),
        .rst_n (reset),
        .load  (head_load),
        .clear (flush),
        .d     (head_in),
        .q     (head_q)
    );

    exm_slot u_skid (
        .clk   (clk),
        .rst_n (reset),
        .load  (skid_load),
        .clear (flush),
        .d     (in_bundle),
        .q     (skid_q)
    );

    // Slots may hold stale data after a pop; only a valid head is exposed.
    assign out_bundle     = out_valid ? head_q : '0;
    assign out_reg_write  = out_bundle.reg_write;
    assign out_mem_write  = out_bundle.mem_write;
    assign out_pc_src     = out_bundle.pc_src;
    assign out_mem_to_reg = out_bundle.mem_to_reg;
    assign out_alu_result = out_bundle.alu_result;
    assign out_write_data = out_bundle.write_data;
    assign out_wa         = out_bundle.wa;
    assign occupancy      = 2'(count_q);

endmodule
